// File: rtl/bsg_dll_period_meter.sv
// bsg_dll_period_meter
//   Measures the period of an asynchronous monitored signal (e.g. a DLL
//   delay-line or ring-oscillator tap) in clk_i cycles. The first rising edge
//   after enable only arms the measurement. Each later rising edge captures the
//   number of clk_i cycles since the previous edge. The count saturates and
//   never wraps.
//
// Ports
//   clk_i       sampling / reference clock
//   reset_n_i   asynchronous active-low reset
//   mon_i       monitored signal, asynchronous to clk_i
//   enable_i    synchronous measurement enable
//   clear_i     synchronous clear of results and state (highest priority)
//   count_o     last captured period in clk_i cycles
//   valid_o     sticky: count_o holds at least one capture since clear/reset
//   update_o    one-cycle pulse on each capture
//   overflow_o  the last capture saturated
module bsg_dll_period_meter #(
   parameter int unsigned width_p       = 8,
   parameter int unsigned sync_stages_p = 2
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               mon_i,
   input  logic               enable_i,
   input  logic               clear_i,
   output logic [width_p-1:0] count_o,
   output logic               valid_o,
   output logic               update_o,
   output logic               overflow_o
);

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      MEAS
   } state_e;

   localparam logic [width_p-1:0] CntOne = width_p'(1);

   state_e                   state_q;
   logic [sync_stages_p-1:0] sync_q;
   logic [sync_stages_p:0]   prime_q;
   logic                     dly_q;
   logic                     sync_out;
   logic                     rise;
   logic [width_p-1:0]       cnt_q, cnt_d;
   logic                     sat_q, sat_d;

   assign sync_out = sync_q[sync_stages_p-1];

   // prime_q fills with ones after reset. A rise is qualified only once both
   // sync_out and dly_q hold real samples of mon_i. Without this, mon_i held
   // high through reset release would look like a fresh rising edge.
   assign rise = prime_q[sync_stages_p] & sync_out & ~dly_q;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         sync_q  <= '0;
         prime_q <= '0;
         dly_q   <= 1'b0;
      end else begin
         sync_q  <= {sync_q[sync_stages_p-2:0], mon_i};
         prime_q <= {prime_q[sync_stages_p-1:0], 1'b1};
         dly_q   <= sync_out;
      end
   end

   // Saturating period counter: once at all-ones it sticks and flags sat.
   always_comb begin
      cnt_d = cnt_q;
      sat_d = sat_q;
      if (cnt_q == '1) begin
         sat_d = 1'b1;
      end else begin
         cnt_d = cnt_q + CntOne;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         sat_q      <= 1'b0;
         count_o    <= '0;
         valid_o    <= 1'b0;
         update_o   <= 1'b0;
         overflow_o <= 1'b0;
      end else begin
         update_o <= 1'b0;
         if (clear_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sat_q      <= 1'b0;
            count_o    <= '0;
            valid_o    <= 1'b0;
            overflow_o <= 1'b0;
         end else if (!enable_i) begin
            // Results are held while disabled; only the measurement restarts.
            state_q <= IDLE;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  state_q <= ARM;
                  cnt_q   <= '0;
                  sat_q   <= 1'b0;
               end
               ARM: begin
                  if (rise) begin
                     state_q <= MEAS;
                     cnt_q   <= CntOne;
                     sat_q   <= 1'b0;
                  end
               end
               MEAS: begin
                  if (rise) begin
                     count_o    <= cnt_q;
                     overflow_o <= sat_q;
                     valid_o    <= 1'b1;
                     update_o   <= 1'b1;
                     cnt_q      <= CntOne;
                     sat_q      <= 1'b0;
                  end else begin
                     cnt_q <= cnt_d;
                     sat_q <= sat_d;
                  end
               end
               default: begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  sat_q   <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bsg_dll_period_meter.sv
// tb_bsg_dll_period_meter
//   Scoreboard bench for bsg_dll_period_meter (width_p=8, sync_stages_p=2).
//   Stimulus pushes expected captures into a queue. A monitor pops and
//   compares each one whenever update_o is seen.
module tb_bsg_dll_period_meter;

   logic       clk_i = 1'b0;
   logic       reset_n_i;
   logic       mon_i;
   logic       enable_i;
   logic       clear_i;
   logic [7:0] count_o;
   logic       valid_o;
   logic       update_o;
   logic       overflow_o;

   typedef struct {
      int cnt;
      int ovf;
   } exp_t;

   exp_t sbq[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   bsg_dll_period_meter #(
      .width_p      (8),
      .sync_stages_p(2)
   ) dut (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .mon_i     (mon_i),
      .enable_i  (enable_i),
      .clear_i   (clear_i),
      .count_o   (count_o),
      .valid_o   (valid_o),
      .update_o  (update_o),
      .overflow_o(overflow_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input int c, input int o);
      exp_t e;
      e.cnt = c;
      e.ovf = o;
      sbq.push_back(e);
   endtask

   // Called at a negedge; rise-to-rise interval is hi+lo cycles.
   task automatic pulse(input int hi, input int lo);
      mon_i = 1'b1;
      repeat (hi) @(negedge clk_i);
      mon_i = 1'b0;
      repeat (lo) @(negedge clk_i);
   endtask

   task automatic do_clear(input string name);
      clear_i = 1'b1;
      @(negedge clk_i);
      clear_i = 1'b0;
      chk({name, "_count"}, int'(count_o), 0);
      chk({name, "_valid"}, int'(valid_o), 0);
      chk({name, "_ovf"}, int'(overflow_o), 0);
      repeat (2) @(negedge clk_i);
   endtask

   // Monitor: compare every capture against the scoreboard.
   always @(negedge clk_i) begin
      if (update_o) begin
         if (sbq.size() == 0) begin
            chk("unexpected_update", 1, 0);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("cap_count", int'(count_o), e.cnt);
            chk("cap_ovf", int'(overflow_o), e.ovf);
            chk("cap_valid", int'(valid_o), 1);
         end
      end
   end

   initial begin
      reset_n_i = 1'b0;
      mon_i     = 1'b0;
      enable_i  = 1'b0;
      clear_i   = 1'b0;
      repeat (3) @(negedge clk_i);
      chk("rst_count", int'(count_o), 0);
      chk("rst_valid", int'(valid_o), 0);
      chk("rst_update", int'(update_o), 0);
      chk("rst_ovf", int'(overflow_o), 0);
      reset_n_i = 1'b1;
      @(negedge clk_i);
      enable_i = 1'b1;
      repeat (3) @(negedge clk_i);

      // Period 10: first rise arms, three captures of 10.
      push(10, 0); push(10, 0); push(10, 0);
      repeat (4) pulse(5, 5);
      repeat (4) @(negedge clk_i);

      // Period 300 saturates at 255, then period 20 measured cleanly.
      do_clear("clr1");
      push(255, 1); push(255, 1); push(20, 0);
      repeat (2) pulse(150, 150);
      repeat (2) pulse(10, 10);
      repeat (4) @(negedge clk_i);

      // Clear coincides with a detected rise: no capture, outputs zeroed.
      do_clear("clr2");
      push(10, 0);
      repeat (2) pulse(5, 5);
      mon_i = 1'b1;
      repeat (2) @(negedge clk_i);
      clear_i = 1'b1;
      @(negedge clk_i);
      clear_i = 1'b0;
      chk("clr_rise_count", int'(count_o), 0);
      chk("clr_rise_valid", int'(valid_o), 0);
      repeat (2) @(negedge clk_i);
      mon_i = 1'b0;
      repeat (5) @(negedge clk_i);
      push(10, 0);
      repeat (2) pulse(5, 5);
      repeat (4) @(negedge clk_i);

      // Enable dropped mid-period: result held, re-arm and re-measure.
      do_clear("clr3");
      push(10, 0);
      repeat (2) pulse(5, 5);
      mon_i    = 1'b1;
      enable_i = 1'b0;
      repeat (3) @(negedge clk_i);
      chk("dis_count", int'(count_o), 10);
      chk("dis_valid", int'(valid_o), 1);
      enable_i = 1'b1;
      repeat (2) @(negedge clk_i);
      mon_i = 1'b0;
      repeat (5) @(negedge clk_i);
      push(12, 0);
      repeat (2) pulse(6, 6);
      repeat (4) @(negedge clk_i);

      // Fastest detectable rate: period 2.
      do_clear("clr4");
      push(2, 0); push(2, 0); push(2, 0); push(2, 0);
      repeat (5) pulse(1, 1);
      repeat (4) @(negedge clk_i);

      // Async reset between edges in MEAS with mon_i high.
      do_clear("clr5");
      push(10, 0); push(10, 0);
      repeat (2) pulse(5, 5);
      mon_i = 1'b1;
      repeat (4) @(negedge clk_i);
      #2;
      reset_n_i = 1'b0;
      #1;
      chk("arst_count", int'(count_o), 0);
      chk("arst_valid", int'(valid_o), 0);
      chk("arst_update", int'(update_o), 0);
      chk("arst_ovf", int'(overflow_o), 0);
      repeat (2) @(negedge clk_i);
      reset_n_i = 1'b1;
      repeat (4) @(negedge clk_i);
      mon_i = 1'b0;
      repeat (4) @(negedge clk_i);
      push(10, 0);
      repeat (2) pulse(5, 5);

      for (int i = 0; i < 200 && sbq.size() != 0; i++) @(negedge clk_i);
      chk("pending_captures", sbq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
